// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce_edge input conditioner.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronizes a bouncing level, qualifies it with a run-length counter and
// emits a clean registered level plus one-cycle rise/fall strobes.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic sample_en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (din),
        .q_o  (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s && sample_en) begin
                    // A single required sample means the first qualified mismatch commits.
                    if (STABLE_CYCLES == 1) begin
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                        state_d = STABLE_HI;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            STABLE_HI: begin
                if (!s && sample_en) begin
                    if (STABLE_CYCLES == 1) begin
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                        state_d = STABLE_LO;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (sample_en) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = STABLE_HI;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (sample_en) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = STABLE_LO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed and randomized bench for debounce_edge against a run-length reference model.
module tb_debounce_edge;

    localparam int SS = 2;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic reset, din, sample_en;
    logic dout, rise, fall, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_no  = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int rise_edge = -1;
    int fall_edge = -1;

    // Reference model: synchronizer as a shift array, filter as a run length.
    logic m_sync [SS];
    logic m_dout, m_rise, m_fall;
    int   m_run;

    debounce_edge #(
        .SYNC_STAGES  (SS),
        .STABLE_CYCLES(SC),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .sample_en(sample_en),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic d, input logic en, input logic rst);
        logic s;
        s = m_sync[SS-1];
        if (rst) begin
            for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
            m_dout = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s == m_dout) begin
                m_run = 0;
            end else if (en) begin
                m_run++;
                if (m_run == SC) begin
                    m_dout = s;
                    m_rise = s;
                    m_fall = !s;
                    m_run  = 0;
                end
            end
            for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = d;
        end
    endtask

    // Drive inputs, take one edge, update the model, then compare 1 time unit later.
    task automatic tick(input logic d, input logic en, input logic rst);
        din       = d;
        sample_en = en;
        reset     = rst;
        @(posedge clk);
        model_edge(d, en, rst);
        edge_no++;
        #1;
        if (rise === 1'b1) begin rise_cnt++; rise_edge = edge_no; end
        if (fall === 1'b1) begin fall_cnt++; fall_edge = edge_no; end
        chk("dout", dout, m_dout);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("busy", busy, (m_run != 0));
        chk("rise_fall_exclusive", rise & fall, 1'b0);
    endtask

    initial begin
        int base;
        int hold;
        logic rd, re, rr;
        for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
        m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
        din = 1'b0; sample_en = 1'b1; reset = 1'b1;

        // 1: reset for two edges, then held state after release
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk("reset_dout", dout, 1'b0);
        chk("reset_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
        chk("post_reset_dout", dout, 1'b0);

        // 2: clean rise, six-edge latency
        rise_cnt = 0;
        base = edge_no;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (i == 3) chk("lat_busy_e3", busy, 1'b1);
            if (i == 5) chk("lat_dout_e5", dout, 1'b0);
            if (i == 6) begin
                chk("lat_dout_e6", dout, 1'b1);
                chk("lat_rise_e6", rise, 1'b1);
                chk("lat_busy_e6", busy, 1'b0);
            end
            if (i == 7) chk("lat_rise_e7", rise, 1'b0);
        end
        chk_int("lat_rise_edge", rise_edge - base, 6);

        // return to 0 before the glitch test
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
        chk("back_low", dout, 1'b0);

        // 3: three-cycle glitch is rejected
        rise_cnt = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0);
        chk("glitch_dout", dout, 1'b0);
        chk("glitch_busy", busy, 1'b0);
        chk_int("glitch_rises", rise_cnt, 0);

        // 4: bounce every 2 cycles, then hold high
        rise_cnt = 0;
        base = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) base = edge_no;
            tick(((i / 2) % 2) == 0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
        chk_int("bounce_rises", rise_cnt, 1);
        chk_int("bounce_rise_edge", rise_edge - base, 6);

        // 5: sparse sample_en, falling edge from dout=1
        fall_cnt = 0;
        for (int i = 0; i < 30; i++) tick(1'b0, (i % 3) == 2, 1'b0);
        chk_int("sparse_falls", fall_cnt, 1);
        chk("sparse_dout", dout, 1'b0);

        // 6: reset in WAIT_HI with count 2 abandons the change
        rise_cnt = 0;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
        chk("pre_reset_busy", busy, 1'b1);
        base = edge_no;
        tick(1'b1, 1'b1, 1'b1);
        chk("mid_reset_dout", dout, 1'b0);
        chk("mid_reset_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0);
        chk_int("reset_abandon_rises", rise_cnt, 1);
        chk_int("reset_rise_edge", rise_edge - (base + 1), 6);

        // randomized run: random hold lengths, qualifying enable and rare resets
        for (int n = 0; n < 300; n++) begin
            rd = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 10);
            for (int k = 0; k < hold; k++) begin
                re = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 199) == 0);
                tick(rd, re, rr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
